div_ratio_detect: RTL

DIV_RATIO_DETECT -- requirements
Module: div_ratio_detect

---
 rtl/div_ratio_detect.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/div_ratio_detect.sv
// Divide-ratio detector: measures the spacing of en_in pulses, recognises
// power-of-two periods and locks once the same ratio repeats LOCK_CNT times.
module div_ratio_detect #(
    parameter int LOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en_in,
    output logic       lock,
    output logic [3:0] dnum_out,
    output logic       bypass,
    output logic [7:0] period_out,
    output logic       err
);

    // state  | meaning
    // IDLE   | waiting for first pulse, no measurement yet
    // MEAS   | measuring, no candidate ratio
    // TRACK  | candidate ratio held in cand, match counts repeats
    // LOCKED | ratio stable, dnum_out valid
    typedef enum logic [1:0] {IDLE, MEAS, TRACK, LOCKED} state_t;

    state_t     state, state_nxt;
    logic [7:0] icnt;
    logic [3:0] cand, cand_nxt;
    logic [2:0] match, match_nxt;
    logic [3:0] match_inc;
    logic       lock_nxt, bypass_nxt, err_nxt;
    logic [3:0] dnum_nxt;
    logic       legal;
    logic [3:0] code;
    logic       timeout;

    always_comb begin
        legal = 1'b1;
        code  = 4'd0;
        case (icnt)
            8'd1:    code = 4'd0;
            8'd2:    code = 4'd2;
            8'd4:    code = 4'd3;
            8'd8:    code = 4'd4;
            8'd16:   code = 4'd5;
            8'd32:   code = 4'd6;
            8'd64:   code = 4'd7;
            8'd128:  code = 4'd8;
            default: legal = 1'b0;
        endcase
    end

    assign timeout   = !en_in && (icnt == 8'd128) && (state != IDLE);
    assign match_inc = {1'b0, match} + 4'd1;

    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        match_nxt  = match;
        lock_nxt   = lock;
        dnum_nxt   = dnum_out;
        bypass_nxt = bypass;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (en_in) state_nxt = MEAS;
            end
            MEAS: begin
                if (timeout) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (en_in) begin
                    if (!legal) begin
                        err_nxt = 1'b1;
                    end else begin
                        cand_nxt  = code;
                        match_nxt = 3'd1;
                        if (LOCK_CNT <= 1) begin
                            state_nxt  = LOCKED;
                            lock_nxt   = 1'b1;
                            dnum_nxt   = code;
                            bypass_nxt = (code == 4'd0);
                        end else begin
                            state_nxt = TRACK;
                        end
                    end
                end
            end
            TRACK: begin
                if (timeout) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (en_in) begin
                    if (!legal) begin
                        err_nxt   = 1'b1;
                        state_nxt = MEAS;
                    end else if (code == cand) begin
                        if (match_inc >= 4'(LOCK_CNT)) begin
                            state_nxt  = LOCKED;
                            lock_nxt   = 1'b1;
                            dnum_nxt   = cand;
                            bypass_nxt = (cand == 4'd0);
                        end else begin
                            match_nxt = match_inc[2:0];
                        end
                    end else begin
                        cand_nxt  = code;
                        match_nxt = 3'd1;
                    end
                end
            end
            LOCKED: begin
                // dnum_out is deliberately left alone on every exit path
                if (timeout) begin
                    err_nxt    = 1'b1;
                    lock_nxt   = 1'b0;
                    bypass_nxt = 1'b0;
                    state_nxt  = IDLE;
                end else if (en_in) begin
                    if (!legal) begin
                        err_nxt    = 1'b1;
                        lock_nxt   = 1'b0;
                        bypass_nxt = 1'b0;
                        state_nxt  = MEAS;
                    end else if (code != dnum_out) begin
                        err_nxt    = 1'b1;
                        lock_nxt   = 1'b0;
                        bypass_nxt = 1'b0;
                        cand_nxt   = code;
                        match_nxt  = 3'd1;
                        state_nxt  = TRACK;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            icnt       <= 8'd0;
            cand       <= 4'd0;
            match      <= 3'd0;
            lock       <= 1'b0;
            dnum_out   <= 4'd0;
            bypass     <= 1'b0;
            period_out <= 8'd0;
            err        <= 1'b0;
        end else if (clr) begin
            state      <= IDLE;
            icnt       <= 8'd0;
            cand       <= 4'd0;
            match      <= 3'd0;
            lock       <= 1'b0;
            dnum_out   <= 4'd0;
            bypass     <= 1'b0;
            period_out <= 8'd0;
            err        <= 1'b0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            match    <= match_nxt;
            lock     <= lock_nxt;
            dnum_out <= dnum_nxt;
            bypass   <= bypass_nxt;
            err      <= err_nxt;
            if (en_in)
                icnt <= 8'd1;
            else if (icnt != 8'd128)
                icnt <= icnt + 8'd1;
            if (en_in && (state != IDLE))
                period_out <= icnt;
        end
    end

endmodule
